// File: rtl/bcd_display_mux.sv
// bcd_display_mux: latches a 3-digit packed BCD value on a load strobe and
// time-multiplexes it onto a 3-digit 7-segment display. Leading zeros can be
// blanked, and invalid nibbles are shown as "-" and flagged on bcd_err.
module bcd_display_mux #(
  parameter int REFRESH_CYCLES = 100000,
  parameter bit LZ_BLANK       = 1'b1,
  parameter bit SEG_ACT_LOW    = 1'b1,
  parameter bit AN_ACT_LOW     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] bcd_in,
  input  logic        load,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic        bcd_err
);

  localparam int          CW      = $clog2(REFRESH_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_CYCLES - 1);
  localparam logic [6:0]  SEG_OFF = {7{SEG_ACT_LOW}};
  localparam logic [2:0]  AN_OFF  = {3{AN_ACT_LOW}};
  localparam logic [6:0]  SEG_DASH = 7'h40;

  logic [11:0]   shadow_q, shadow_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    an_q, an_d;

  logic [3:0]    dig_hund, dig_tens, dig_ones;
  logic [3:0]    dig_sel;
  logic          blank;
  logic [6:0]    seg_act;
  logic [2:0]    an_act;

  // Active-high segment pattern for one nibble; A..F show a dash.
  function automatic logic [6:0] decode7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  // True when any nibble of a packed 3-digit value is outside 0..9.
  function automatic logic has_bad_nibble(input logic [11:0] v);
    return (v[11:8] > 4'd9) || (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
  endfunction

  // Shadow register and error flag: last load wins, flag tracks the shadow.
  always_comb begin
    shadow_d = shadow_q;
    err_d    = err_q;
    if (load) begin
      shadow_d = bcd_in;
      err_d    = has_bad_nibble(bcd_in);
    end
  end

  // Refresh timer and digit index; independent of load activity.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end
  end

  assign dig_hund = shadow_q[11:8];
  assign dig_tens = shadow_q[7:4];
  assign dig_ones = shadow_q[3:0];

  // Digit select, leading-zero blanking and polarity for the output register.
  // Comparing against zero keeps invalid nibbles from ever being blanked.
  always_comb begin
    dig_sel = dig_ones;
    blank   = 1'b0;
    an_act  = 3'b001;
    case (idx_q)
      2'd1: begin
        dig_sel = dig_tens;
        blank   = LZ_BLANK && (dig_hund == 4'd0) && (dig_tens == 4'd0);
        an_act  = 3'b010;
      end
      2'd2: begin
        dig_sel = dig_hund;
        blank   = LZ_BLANK && (dig_hund == 4'd0);
        an_act  = 3'b100;
      end
      default: begin
        dig_sel = dig_ones;
        blank   = 1'b0;
        an_act  = 3'b001;
      end
    endcase
    seg_act = decode7(dig_sel);
    if (blank) begin
      seg_act = 7'h00;
      an_act  = 3'b000;
    end
    seg_d = SEG_ACT_LOW ? ~seg_act : seg_act;
    an_d  = AN_ACT_LOW  ? ~an_act  : an_act;
  end

  // Shadow value and error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q <= 12'h000;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      err_q    <= err_d;
    end
  end

  // Scan timer and digit index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Registered display outputs, built from the index/shadow of the prior cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q <= SEG_OFF;
      an_q  <= AN_OFF;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg     = seg_q;
  assign an      = an_q;
  assign bcd_err = err_q;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Testbench for bcd_display_mux: directed scenarios, a full 000..999 sweep
// and random traffic, all checked against a cycle-count based reference.
module tb_bcd_display_mux;

  localparam int R = 4;

  logic        clk;
  logic        rst_n;
  logic [11:0] bcd_in;
  logic        load;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic        bcd_err;

  int n_tests;
  int n_fail;

  // Reference state: shadow value, error flag and edges since last reset.
  int m_val;
  int m_k;
  bit m_err;

  logic [6:0] dec_tbl [10];

  bcd_display_mux #(
    .REFRESH_CYCLES(R),
    .LZ_BLANK(1'b1),
    .SEG_ACT_LOW(1'b1),
    .AN_ACT_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bcd_in(bcd_in),
    .load(load),
    .seg(seg),
    .an(an),
    .bcd_err(bcd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit bad_val(input int v);
    return ((v / 256) % 16 > 9) || ((v / 16) % 16 > 9) || (v % 16 > 9);
  endfunction

  // Expected display for a slot index and a shadow value (active-low outputs).
  task automatic expect_disp(input int slot, input int v,
                             output logic [6:0] e_seg, output logic [2:0] e_an);
    int h, t, o, d;
    bit blank;
    logic [6:0] pat;
    h = (v / 256) % 16;
    t = (v / 16) % 16;
    o = v % 16;
    d = (slot == 0) ? o : (slot == 1) ? t : h;
    blank = (slot == 2 && h == 0) || (slot == 1 && h == 0 && t == 0);
    pat = (d <= 9) ? dec_tbl[d] : 7'h40;
    if (blank) begin
      e_seg = 7'h7F;
      e_an  = 3'b111;
    end else begin
      e_seg = ~pat;
      e_an  = ~(3'b001 << slot);
    end
  endtask

  // One clock: apply inputs, advance the reference, check outputs after the edge.
  task automatic step(input bit rst_v, input bit ld, input int v);
    logic [6:0] e_seg;
    logic [2:0] e_an;
    rst_n  = rst_v;
    load   = ld;
    bcd_in = 12'(v);
    @(posedge clk);
    if (!rst_v) begin
      e_seg = 7'h7F;
      e_an  = 3'b111;
      m_k   = 0;
      m_val = 0;
      m_err = 0;
    end else begin
      expect_disp((m_k / R) % 3, m_val, e_seg, e_an);
      m_k++;
      if (ld) begin
        m_val = v;
        m_err = bad_val(v);
      end
    end
    #1;
    chk("seg", 32'(seg), 32'(e_seg));
    chk("an", 32'(an), 32'(e_an));
    chk("bcd_err", 32'(bcd_err), 32'(m_err));
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0);
  endtask

  initial begin
    dec_tbl[0] = 7'h3F; dec_tbl[1] = 7'h06; dec_tbl[2] = 7'h5B; dec_tbl[3] = 7'h4F;
    dec_tbl[4] = 7'h66; dec_tbl[5] = 7'h6D; dec_tbl[6] = 7'h7D; dec_tbl[7] = 7'h07;
    dec_tbl[8] = 7'h7F; dec_tbl[9] = 7'h6F;
    n_tests = 0;
    n_fail  = 0;
    m_val = 0; m_k = 0; m_err = 0;
    rst_n = 1'b0; load = 1'b0; bcd_in = 12'h000;

    // Reset held, then release: ones slot shows "0".
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    chk("post_rst_seg", 32'(seg), 32'h40);
    chk("post_rst_an", 32'(an), 32'b110);
    idle(6);

    // Full 3-digit value, two scan periods.
    step(1'b1, 1'b1, 12'h123);
    idle(26);

    // Leading-zero blanking cases.
    step(1'b1, 1'b1, 12'h007);
    idle(13);
    step(1'b1, 1'b1, 12'h070);
    idle(13);

    // Invalid nibble then recovery.
    step(1'b1, 1'b1, 12'h1A5);
    chk("err_set", 32'(bcd_err), 32'd1);
    idle(13);
    step(1'b1, 1'b1, 12'h999);
    chk("err_clr", 32'(bcd_err), 32'd0);
    idle(5);

    // Load coinciding with a digit switch.
    while ((m_k % R) != R - 1) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 12'h456);
    idle(14);

    // Reset in the middle of the hundreds slot.
    step(1'b1, 1'b1, 12'h789);
    while (!((m_k / R) % 3 == 2 && (m_k % R) == 1)) step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    chk("midrst_an", 32'(an), 32'b111);
    step(1'b1, 1'b0, 0);
    chk("midrst_restart_an", 32'(an), 32'b110);
    idle(13);

    // Sweep every valid value through all three slots.
    for (int v = 0; v < 1000; v++) begin
      step(1'b1, 1'b1, (v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
      idle(R * 3);
    end

    // Random traffic, including invalid nibbles and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) == 0),
           int'($urandom_range(0, 4095)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
